// File: rtl/rom_arbiter_pkg.sv
// Shared types for the two-port StrataFlash read arbiter.
// State encoding, port ids and bus widths.
package rom_arbiter_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  localparam logic PORT_SND = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester and romController signals of the arbiter.
// slave = arbiter side, master = environment side.
interface rom_arbiter_if;
  import rom_arbiter_pkg::*;

  addr_t p0_addr;
  logic  p0_load;
  data_t p0_data;
  logic  p0_ready;
  logic  p0_busy;

  addr_t p1_addr;
  logic  p1_load;
  data_t p1_data;
  logic  p1_ready;
  logic  p1_busy;

  addr_t rom_addr;
  logic  rom_load;
  data_t rom_data;
  logic  rom_ready;

  logic  timeout_err;

  modport slave (
    input  p0_addr, p0_load,
    output p0_data, p0_ready, p0_busy,
    input  p1_addr, p1_load,
    output p1_data, p1_ready, p1_busy,
    output rom_addr, rom_load,
    input  rom_data, rom_ready,
    output timeout_err
  );

  modport master (
    output p0_addr, p0_load,
    input  p0_data, p0_ready, p0_busy,
    output p1_addr, p1_load,
    input  p1_data, p1_ready, p1_busy,
    input  rom_addr, rom_load,
    output rom_data, rom_ready,
    input  timeout_err
  );

endinterface

// File: rtl/rom_req_slot.sv
// One requester slot: pending flag, address latch,
// busy flag and the data/ready return register.
module rom_req_slot
  import rom_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  addr_t addr,
  input  logic  take,
  input  logic  active,
  input  logic  done,
  input  data_t result,
  output logic  pend,
  output addr_t addr_q,
  output data_t data,
  output logic  ready,
  output logic  busy
);

  logic pend_next;

  // A load in the grant cycle re-arms the slot.
  always_comb begin
    pend_next = load | (pend & ~take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= 1'b0;
      addr_q <= '0;
      data   <= '0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      pend  <= pend_next;
      ready <= done;
      busy  <= pend_next | active;
      if (load) addr_q <= addr;
      if (done) data <= result;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port romController arbiter: fixed priority to the
// sound port with a starvation guard and a read watchdog.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int    STARVE_LIMIT = 4,
  parameter int    TIMEOUT      = 255,
  parameter data_t TO_DATA      = 16'hFFFF
) (
  input logic          clk,
  input logic          rst,
  rom_arbiter_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  state_t state;
  state_t state_next;

  logic  grant;
  logic  grant_next;
  logic  pick;
  logic  pend0;
  logic  pend1;
  addr_t addr0;
  addr_t addr1;
  addr_t rom_addr_q;
  logic  terr;

  logic [WD_W-1:0] wd;
  logic [SC_W-1:0] starve;

  logic  finish;
  logic  req;
  logic  rom_load;
  logic  done;
  logic  take0;
  logic  take1;
  logic  done0;
  logic  done1;
  logic  act0;
  logic  act1;
  logic  timed_out;
  data_t result;

  // DMA wins only once the sound port has hogged the ROM.
  always_comb begin
    pick = PORT_DMA;
    if (pend0 && !(pend1 && starve == SC_MAX)) pick = PORT_SND;
  end

  assign finish = bus.rom_ready || (wd == WD_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (pend0 || pend1) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (finish) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req      = 1'b0;
    rom_load = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE:  req = pend0 || pend1;
      ST_ISSUE: rom_load = 1'b1;
      ST_WAIT:  done = finish;
      default:  ;
    endcase
  end

  assign take0      = req && (pick == PORT_SND);
  assign take1      = req && (pick == PORT_DMA);
  assign grant_next = req ? pick : grant;
  assign done0      = done && (grant == PORT_SND);
  assign done1      = done && (grant == PORT_DMA);
  assign timed_out  = done && !bus.rom_ready;
  assign result     = bus.rom_ready ? bus.rom_data : TO_DATA;
  assign act0 = (state_next != ST_IDLE) && (grant_next == PORT_SND);
  assign act1 = (state_next != ST_IDLE) && (grant_next == PORT_DMA);

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= PORT_SND;
      rom_addr_q <= '0;
      wd         <= '0;
      starve     <= '0;
      terr       <= 1'b0;
    end else begin
      grant <= grant_next;
      if (req) rom_addr_q <= (pick == PORT_DMA) ? addr1 : addr0;
      if (state == ST_ISSUE) wd <= '0;
      else if (state == ST_WAIT && !finish) wd <= wd + 1'b1;
      if (!pend1 || take1) starve <= '0;
      else if (take0 && starve != SC_MAX) starve <= starve + 1'b1;
      if (timed_out) terr <= 1'b1;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.rom_load    = rom_load;
  assign bus.timeout_err = terr;

  rom_req_slot u_snd (
    .clk    (clk),
    .rst    (rst),
    .load   (bus.p0_load),
    .addr   (bus.p0_addr),
    .take   (take0),
    .active (act0),
    .done   (done0),
    .result (result),
    .pend   (pend0),
    .addr_q (addr0),
    .data   (bus.p0_data),
    .ready  (bus.p0_ready),
    .busy   (bus.p0_busy)
  );

  rom_req_slot u_dma (
    .clk    (clk),
    .rst    (rst),
    .load   (bus.p1_load),
    .addr   (bus.p1_addr),
    .take   (take1),
    .active (act1),
    .done   (done1),
    .result (result),
    .pend   (pend1),
    .addr_q (addr1),
    .data   (bus.p1_data),
    .ready  (bus.p1_ready),
    .busy   (bus.p1_busy)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios plus random
// traffic scored against a transaction-level model.
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  localparam int    STARVE  = 4;
  localparam int    TIMEOUT = 255;
  localparam data_t TO_DATA = 16'hFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_arbiter_if bus();

  rom_arbiter #(
    .STARVE_LIMIT (STARVE),
    .TIMEOUT      (TIMEOUT),
    .TO_DATA      (TO_DATA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int passed = 0;
  int total  = 0;
  int nows   = 0;

  bit    mpend [2];
  addr_t maddr [2];
  data_t mdata [2];
  int    mstarve;
  bit    mbusy;
  int    mport;
  bit    mterr;

  int    rdy_due = -1;
  data_t rdy_val;
  bit    rdy_to;

  int    rom_wait  = -1;
  int    rom_delay = 0;
  bit    rom_mute, use_fixed, stray_en, force_stray;
  data_t fixed_val;

  bit    ld [2];
  addr_t lda [2];
  bit    nxt_ld [2];
  addr_t nxt_a [2];

  addr_t obs_addr [$];
  int    obs_rdy [$];
  int    obs_t [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] qa(input int i);
    return (obs_addr.size() > i) ? 32'(obs_addr[i]) : 32'hDEAD_DEAD;
  endfunction

  function automatic int cnt_rdy(input int p);
    int n = 0;
    foreach (obs_rdy[i]) if (obs_rdy[i] == p) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      mpend[p] = 0; maddr[p] = '0; mdata[p] = '0;
      ld[p] = 0; nxt_ld[p] = 0;
    end
    mstarve = 0; mbusy = 0; mport = 0; mterr = 0;
    rdy_due = -1; rdy_to = 0; rom_wait = -1;
  endtask

  // One clock of stimulus and scoring, all at the falling edge.
  task automatic cyc();
    int    g;
    bit    exp_load;
    bit    exp_r;
    logic  rdy [2];
    data_t dat [2];
    logic  bsy [2];
    data_t v;
    @(negedge clk);
    nows++;
    rdy[0] = bus.p0_ready; rdy[1] = bus.p1_ready;
    dat[0] = bus.p0_data;  dat[1] = bus.p1_data;
    bsy[0] = bus.p0_busy;  bsy[1] = bus.p1_busy;
    if (bus.rom_load === 1'b1) begin
      obs_addr.push_back(bus.rom_addr);
      obs_t.push_back(nows);
    end
    exp_load = !mbusy && (mpend[0] || mpend[1]);
    chk("rom_load", bus.rom_load, exp_load);
    if (exp_load) begin
      g = (mpend[0] && !(mpend[1] && mstarve == STARVE)) ? 0 : 1;
      chk("rom_addr", bus.rom_addr, maddr[g]);
      if (g == 1) mstarve = 0;
      else if (mpend[1]) mstarve++;
      mpend[g] = 0; mbusy = 1; mport = g;
      if (rom_mute) begin
        // one ISSUE cycle, TIMEOUT+1 WAIT edges, then the pulse
        rdy_due = nows + TIMEOUT + 2;
        rdy_val = TO_DATA; rdy_to = 1;
      end else begin
        rom_wait = (rom_delay > 0) ? rom_delay : $urandom_range(1, 6);
      end
    end
    for (int p = 0; p < 2; p++) begin
      exp_r = (nows == rdy_due) && (mport == p);
      chk(p == 0 ? "p0_ready" : "p1_ready", rdy[p], exp_r);
      if (rdy[p] === 1'b1) obs_rdy.push_back(p);
      if (exp_r) begin
        mdata[p] = rdy_val;
        if (rdy_to) mterr = 1;
      end
    end
    if (nows == rdy_due) begin
      mbusy = 0; rdy_due = -1; rdy_to = 0;
    end
    chk("p0_data", dat[0], mdata[0]);
    chk("p1_data", dat[1], mdata[1]);
    chk("timeout_err", bus.timeout_err, mterr);
    for (int p = 0; p < 2; p++) begin
      if (ld[p]) begin mpend[p] = 1; maddr[p] = lda[p]; end
      chk(p == 0 ? "p0_busy" : "p1_busy", bsy[p],
          mpend[p] || (mbusy && mport == p));
    end
    bus.rom_ready = 1'b0;
    if (rom_wait == 0) begin
      v = use_fixed ? fixed_val : data_t'($urandom);
      bus.rom_ready = 1'b1; bus.rom_data = v;
      rdy_due = nows + 1; rdy_val = v; rom_wait = -1;
    end else if (rom_wait > 0) begin
      rom_wait--;
    end else if (!mbusy && (force_stray ||
                 (stray_en && $urandom_range(0, 3) == 0))) begin
      bus.rom_ready = 1'b1; bus.rom_data = data_t'($urandom);
      force_stray = 0;
    end
    bus.p0_load = nxt_ld[0]; bus.p0_addr = nxt_a[0];
    bus.p1_load = nxt_ld[1]; bus.p1_addr = nxt_a[1];
    for (int p = 0; p < 2; p++) begin
      ld[p] = nxt_ld[p]; lda[p] = nxt_a[p]; nxt_ld[p] = 0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((mbusy || mpend[0] || mpend[1] || ld[0] || ld[1] ||
            nxt_ld[0] || nxt_ld[1]) && n < budget) begin
      cyc(); n++;
    end
    chk("drain_idle", mbusy || mpend[0] || mpend[1], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.p0_load = 1'b0; bus.p1_load = 1'b0; bus.rom_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rom_load", bus.rom_load, 1'b0);
    chk("rst_rom_addr", bus.rom_addr, '0);
    chk("rst_p0_ready", bus.p0_ready, 1'b0);
    chk("rst_p1_ready", bus.p1_ready, 1'b0);
    chk("rst_p0_data", bus.p0_data, '0);
    chk("rst_p1_data", bus.p1_data, '0);
    chk("rst_p0_busy", bus.p0_busy, 1'b0);
    chk("rst_p1_busy", bus.p1_busy, 1'b0);
    chk("rst_timeout_err", bus.timeout_err, 1'b0);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_rdy.delete(); obs_t.delete();
  endtask

  initial begin
    int t0;
    int n;
    int reloads;
    bus.p0_load = 0; bus.p1_load = 0;
    bus.p0_addr = '0; bus.p1_addr = '0;
    bus.rom_ready = 0; bus.rom_data = '0;
    rom_mute = 0; use_fixed = 0; stray_en = 0; force_stray = 0;
    fixed_val = '0;
    model_reset();
    do_reset();

    // single sound read, ROM answers 16'hBEEF
    clear_obs();
    use_fixed = 1; fixed_val = 16'hBEEF; rom_delay = 3;
    nxt_ld[0] = 1; nxt_a[0] = 24'h000100;
    cyc(); t0 = nows;
    drain(40);
    chk("t1_rom_addr", qa(0), 24'h000100);
    chk("t1_latency", (obs_t.size() > 0) ? obs_t[0] - t0 : -1, 2);
    chk("t1_p0_readies", cnt_rdy(0), 1);
    chk("t1_p1_readies", cnt_rdy(1), 0);
    chk("t1_p0_data", bus.p0_data, 16'hBEEF);
    chk("t1_p1_data", bus.p1_data, 16'h0000);
    use_fixed = 0;

    // simultaneous loads: sound first
    clear_obs();
    rom_delay = 0;
    nxt_ld[0] = 1; nxt_a[0] = 24'h10;
    nxt_ld[1] = 1; nxt_a[1] = 24'h20;
    cyc();
    drain(60);
    chk("t2_first_addr", qa(0), 24'h10);
    chk("t2_second_addr", qa(1), 24'h20);
    chk("t2_ready_order", (obs_rdy.size() == 2) ? obs_rdy[0] : 9, 0);

    // sound keeps reloading while DMA waits
    clear_obs();
    reloads = 0; n = 0;
    nxt_ld[0] = 1; nxt_a[0] = 24'h100;
    nxt_ld[1] = 1; nxt_a[1] = 24'hD000;
    cyc();
    while (obs_addr.size() < 5 && n < 200) begin
      cyc(); n++;
      if (mbusy && mport == 0 && !mpend[0] && !ld[0] && reloads < 4) begin
        reloads++;
        nxt_ld[0] = 1; nxt_a[0] = addr_t'(24'h100 + reloads);
      end
    end
    drain(80);
    chk("t3_grant1", qa(0), 24'h100);
    chk("t3_grant4", qa(3), 24'h103);
    chk("t3_grant5_dma", qa(4), 24'hD000);
    chk("t3_grant6", qa(5), 24'h104);

    // overwrite before grant while DMA is in flight
    clear_obs();
    rom_delay = 8;
    nxt_ld[1] = 1; nxt_a[1] = 24'h777;
    cyc();
    n = 0;
    while (!mbusy && n < 10) begin cyc(); n++; end
    nxt_ld[0] = 1; nxt_a[0] = 24'h1;
    cyc();
    nxt_ld[0] = 1; nxt_a[0] = 24'h2;
    cyc();
    rom_delay = 3;
    drain(60);
    chk("t4_accesses", obs_addr.size(), 2);
    chk("t4_addr", qa(1), 24'h2);
    chk("t4_p0_readies", cnt_rdy(0), 1);

    // ROM never answers
    clear_obs();
    rom_mute = 1;
    nxt_ld[1] = 1; nxt_a[1] = 24'h55;
    cyc();
    drain(400);
    rom_mute = 0;
    chk("t5_p1_readies", cnt_rdy(1), 1);
    chk("t5_p1_data", bus.p1_data, TO_DATA);
    chk("t5_timeout_err", bus.timeout_err, 1'b1);
    nxt_ld[0] = 1; nxt_a[0] = 24'h66;
    cyc();
    drain(40);
    chk("t5_next_ok", cnt_rdy(0), 1);
    chk("t5_err_sticky", bus.timeout_err, 1'b1);

    // reset during WAIT, then a stray rom_ready
    rom_delay = 20;
    nxt_ld[1] = 1; nxt_a[1] = 24'h4242;
    cyc();
    n = 0;
    while (!mbusy && n < 10) begin cyc(); n++; end
    repeat (3) cyc();
    do_reset();
    clear_obs();
    force_stray = 1;
    repeat (4) cyc();
    chk("t6_no_ready", obs_rdy.size(), 0);
    use_fixed = 1; fixed_val = 16'h1234; rom_delay = 2;
    nxt_ld[0] = 1; nxt_a[0] = 24'h99;
    cyc();
    drain(40);
    chk("t6_fresh_ready", cnt_rdy(0), 1);
    chk("t6_fresh_data", bus.p0_data, 16'h1234);
    chk("t6_fresh_addr", qa(0), 24'h99);
    use_fixed = 0;

    // random traffic with stray ROM pulses
    rom_delay = 0; stray_en = 1;
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 2; p++) begin
        nxt_ld[p] = ($urandom_range(0, 2) == 0);
        nxt_a[p]  = addr_t'($urandom);
      end
      cyc();
    end
    stray_en = 0;
    drain(200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
